aw_write_arbiter_2_1: RTL

- Sequencer and arbiter for the 2:1 write-address mux in the AXI interconnect: picks which of two upstream masters (S00/S01) owns the single downstream write path, drives the mux select and gates AW valid/ready.
- Holds the grant through the W burst and the B response (one outstanding write).
- Checks W beat count against the captured AWLEN.

---
 rtl/aw_write_arbiter_2_1_pkg.sv | 17 +
 rtl/aw_write_arbiter_2_1_if.sv | 42 ++++
 rtl/aw_write_arbiter_2_1_picker.sv | 27 ++
 rtl/aw_write_arbiter_2_1.sv | 123 ++++++++++++
 4 files changed

// File: rtl/aw_write_arbiter_2_1_pkg.sv
// Shared definitions for the 2:1 AW arbiter: FSM state encoding, master
// indices and QoS field width.
package aw_write_arbiter_2_1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int QOS_W = 4;

endpackage

// File: rtl/aw_write_arbiter_2_1_if.sv
// Handshake and control bundle between the AW arbiter and the surrounding
// interconnect mux. The slave modport is the arbiter's view.
interface aw_write_arbiter_2_1_if #(
    parameter int S_Aw_len = 8
);
    logic                S00_AXI_awvalid;
    logic                S01_AXI_awvalid;
    logic [3:0]          S00_AXI_awqos;
    logic [3:0]          S01_AXI_awqos;
    logic [S_Aw_len-1:0] Sel_S_AXI_awlen;
    logic                M_AXI_awready;
    logic                M_AXI_wvalid;
    logic                M_AXI_wready;
    logic                M_AXI_wlast;
    logic                M_AXI_bvalid;
    logic                M_AXI_bready;

    logic                Selected_Slave;
    logic                M_AXI_awvalid;
    logic                S00_AXI_awready;
    logic                S01_AXI_awready;
    logic                Wdata_Enable;
    logic                Bresp_Enable;
    logic                Wlast_Mismatch;

    modport slave (
        input  S00_AXI_awvalid, S01_AXI_awvalid, S00_AXI_awqos, S01_AXI_awqos,
        input  Sel_S_AXI_awlen, M_AXI_awready, M_AXI_wvalid, M_AXI_wready,
        input  M_AXI_wlast, M_AXI_bvalid, M_AXI_bready,
        output Selected_Slave, M_AXI_awvalid, S00_AXI_awready, S01_AXI_awready,
        output Wdata_Enable, Bresp_Enable, Wlast_Mismatch
    );

    modport master (
        output S00_AXI_awvalid, S01_AXI_awvalid, S00_AXI_awqos, S01_AXI_awqos,
        output Sel_S_AXI_awlen, M_AXI_awready, M_AXI_wvalid, M_AXI_wready,
        output M_AXI_wlast, M_AXI_bvalid, M_AXI_bready,
        input  Selected_Slave, M_AXI_awvalid, S00_AXI_awready, S01_AXI_awready,
        input  Wdata_Enable, Bresp_Enable, Wlast_Mismatch
    );

endinterface

// File: rtl/aw_write_arbiter_2_1_picker.sv
// Combinational winner selection between two AW requesters: sole requester
// wins, then higher QoS (when enabled), then the master not granted last.
module aw_rr_qos_picker
    import aw_write_arbiter_2_1_pkg::*;
#(
    parameter bit QOS_EN = 1'b1
) (
    input  logic             valid0_i,
    input  logic             valid1_i,
    input  logic [QOS_W-1:0] qos0_i,
    input  logic [QOS_W-1:0] qos1_i,
    input  logic             last_grant_i,
    output logic             winner_o
);

    always_comb begin
        winner_o = ~last_grant_i;
        if (valid0_i && !valid1_i) begin
            winner_o = M0;
        end else if (valid1_i && !valid0_i) begin
            winner_o = M1;
        end else if (QOS_EN && (qos0_i != qos1_i)) begin
            winner_o = (qos1_i > qos0_i) ? M1 : M0;
        end
    end

endmodule

// File: rtl/aw_write_arbiter_2_1.sv
// 2:1 write-path sequencer: arbitrates AW, then holds the grant through the
// W burst and B response, flagging W beat counts that disagree with AWLEN.
module aw_write_arbiter_2_1
    import aw_write_arbiter_2_1_pkg::*;
#(
    parameter int S_Aw_len = 8,
    parameter bit QOS_EN   = 1'b1
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    aw_write_arbiter_2_1_if.slave  bus
);

    state_e              state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_grant_q, last_grant_d;
    logic [S_Aw_len-1:0] beat_cnt_q, beat_cnt_d;
    logic                mism_q, mism_d;

    logic winner;
    logic sel_awvalid;
    logic aw_hs;
    logic w_beat;
    logic awvalid_out, awready0, awready1, wen, ben;

    aw_rr_qos_picker #(
        .QOS_EN (QOS_EN)
    ) u_picker (
        .valid0_i     (bus.S00_AXI_awvalid),
        .valid1_i     (bus.S01_AXI_awvalid),
        .qos0_i       (bus.S00_AXI_awqos),
        .qos1_i       (bus.S01_AXI_awqos),
        .last_grant_i (last_grant_q),
        .winner_o     (winner)
    );

    assign sel_awvalid = (sel_q == M1) ? bus.S01_AXI_awvalid : bus.S00_AXI_awvalid;
    assign aw_hs       = (state_q == ADDR) && sel_awvalid && bus.M_AXI_awready;
    // Beats outside DATA are neither passed nor counted.
    assign w_beat      = (state_q == DATA) && bus.M_AXI_wvalid && bus.M_AXI_wready;

    always_comb begin
        awvalid_out = 1'b0;
        awready0    = 1'b0;
        awready1    = 1'b0;
        wen         = 1'b0;
        ben         = 1'b0;
        case (state_q)
            ADDR: begin
                awvalid_out = sel_awvalid;
                if (sel_q == M1) awready1 = bus.M_AXI_awready;
                else             awready0 = bus.M_AXI_awready;
            end
            DATA:    wen = 1'b1;
            RESP:    ben = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        mism_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.S00_AXI_awvalid || bus.S01_AXI_awvalid) begin
                    sel_d   = winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    beat_cnt_d   = bus.Sel_S_AXI_awlen;
                    last_grant_d = sel_q;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (w_beat) begin
                    // Count saturates at zero so an overlong burst keeps flagging.
                    if (beat_cnt_q != '0) beat_cnt_d = beat_cnt_q - S_Aw_len'(1);
                    if (bus.M_AXI_wlast) begin
                        mism_d  = (beat_cnt_q != '0);
                        state_d = RESP;
                    end else begin
                        mism_d  = (beat_cnt_q == '0);
                    end
                end
            end
            RESP: begin
                if (bus.M_AXI_bvalid && bus.M_AXI_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            sel_q        <= M0;
            last_grant_q <= M1;
            beat_cnt_q   <= '0;
            mism_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            mism_q       <= mism_d;
        end
    end

    assign bus.Selected_Slave  = sel_q;
    assign bus.M_AXI_awvalid   = awvalid_out;
    assign bus.S00_AXI_awready = awready0;
    assign bus.S01_AXI_awready = awready1;
    assign bus.Wdata_Enable    = wen;
    assign bus.Bresp_Enable    = ben;
    assign bus.Wlast_Mismatch  = mism_q;

endmodule
